// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, per-source
// qualification modes and the counter width helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    LOCKWAIT = 2'd0,
    HOLD     = 2'd1,
    RUN      = 2'd2
  } seq_state_t;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  // One spare bit so a counter can hold its own limit value.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/reset_req_filter.sv
// One reset request channel: synchroniser, debouncer and level/edge qualifier
// producing a registered single-bit trigger.
module reset_req_filter
  import reset_seq_pkg::*;
#(
  parameter int         SYNC_STAGES     = 2,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [1:0] MODE            = MODE_FALL
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic trig
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   d;
  logic                   d_prev;
  logic                   trig_next;

  // Synchroniser chain for the raw asynchronous pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign d = s;
    end else begin : g_debounce
      localparam int CW = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt_q;
      logic          d_q;

      // Count consecutive disagreeing samples; any agreement restarts the count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
          d_q   <= 1'b0;
        end else if (s == d_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          d_q   <= s;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      assign d = d_q;
    end
  endgenerate

  // Qualify the debounced value according to the channel mode.
  always_comb begin
    trig_next = 1'b0;
    case (MODE)
      MODE_LEVEL: trig_next = d;
      MODE_RISE:  trig_next = d & ~d_prev;
      MODE_FALL:  trig_next = ~d & d_prev;
      MODE_OFF:   trig_next = 1'b0;
      default:    trig_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_prev <= 1'b0;
      trig   <= 1'b0;
    end else begin
      d_prev <= d;
      trig   <= trig_next;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset manager: waits for a qualified PLL lock, stretches reset after any
// qualified request and keeps a sticky record of what caused the last reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int                     NUM_SRC         = 2,
  parameter int                     SYNC_STAGES     = 2,
  parameter int                     DEBOUNCE_CYCLES = 4,
  parameter int                     LOCK_DELAY      = 255,
  parameter int                     STRETCH_CYCLES  = 16,
  parameter logic [2*NUM_SRC-1:0]   SRC_MODE        = {NUM_SRC{2'b10}}
) (
  input  logic               io_mainClk,
  input  logic               io_asyncReset,
  input  logic               io_pllLocked,
  input  logic [NUM_SRC-1:0] io_resetReq,
  input  logic               io_causeClear,
  output logic               io_systemReset,
  output logic [NUM_SRC:0]   io_resetCause,
  output logic [1:0]         io_state
);

  localparam int LW = cnt_width(LOCK_DELAY);
  localparam int SW = cnt_width(STRETCH_CYCLES);
  localparam logic [LW-1:0] LOCK_LAST    = LW'(LOCK_DELAY - 1);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_CYCLES - 1);

  logic [NUM_SRC-1:0]     trig;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock;
  logic                   any_trig;
  logic                   lock_loss;

  seq_state_t    state_q, state_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [SW-1:0] stretch_cnt_q, stretch_cnt_d;
  logic [NUM_SRC:0] cause_q, cause_d;
  logic          sys_reset_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    reset_req_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .MODE           (SRC_MODE[2*g +: 2])
    ) u_filter (
      .clk (io_mainClk),
      .rst (io_asyncReset),
      .req (io_resetReq[g]),
      .trig(trig[g])
    );
  end

  // PLL lock crosses into the clock domain through the same style of chain.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      lock_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], io_pllLocked};
    end
  end

  assign lock      = lock_sync[SYNC_STAGES-1];
  assign any_trig  = |trig;
  assign lock_loss = (state_q != LOCKWAIT) && !lock;

  // Next-state, counters and cause; lock loss outranks request triggers.
  always_comb begin
    state_d       = state_q;
    lock_cnt_d    = '0;
    stretch_cnt_d = '0;
    case (state_q)
      LOCKWAIT: begin
        if (!lock) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d = HOLD;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      HOLD: begin
        if (!lock) begin
          state_d = LOCKWAIT;
        end else if (any_trig) begin
          stretch_cnt_d = '0;
        end else if (stretch_cnt_q == STRETCH_LAST) begin
          state_d = RUN;
        end else begin
          stretch_cnt_d = stretch_cnt_q + SW'(1);
        end
      end
      RUN: begin
        if (!lock) begin
          state_d = LOCKWAIT;
        end else if (any_trig) begin
          state_d = HOLD;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = LOCKWAIT;
    endcase

    cause_d = (io_causeClear ? '0 : cause_q) | {lock_loss, trig};
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state_q       <= LOCKWAIT;
      lock_cnt_q    <= '0;
      stretch_cnt_q <= '0;
      cause_q       <= '0;
      sys_reset_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      stretch_cnt_q <= stretch_cnt_d;
      cause_q       <= cause_d;
      sys_reset_q   <= (state_d != RUN);
    end
  end

  assign io_systemReset = sys_reset_q;
  assign io_resetCause  = cause_q;
  assign io_state       = state_q;

endmodule
